// File: rtl/controle_somador_serial_pkg.sv
// -----------------------------------------------------------------------------
// controle_somador_serial_pkg
//   Shared definitions for the serial adder controller:
//     - estado_t   : FSM state encoding (OCIOSO / SOMANDO / PRONTO)
//     - LARG_BLOCO : width of the shared adder slice (somador_4_bits)
// -----------------------------------------------------------------------------
package controle_somador_serial_pkg;

  // Width of one adder slice. This is set by somador_4_bits itself, so it is a
  // package constant rather than a module parameter.
  localparam int LARG_BLOCO = 4;

  // Controller states. The encodings are fixed so that external checkers can
  // decode the debug state output directly.
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,  // idle, waiting for operands
    SOMANDO = 2'd1,  // one slice per cycle, LSB slice first
    PRONTO  = 2'd2   // result held until the consumer takes it
  } estado_t;

endpackage : controle_somador_serial_pkg

// File: rtl/somador_4_bits.sv
// -----------------------------------------------------------------------------
// somador_4_bits
//   Purely combinational 4-bit ripple-carry adder slice.
//   Ports:
//     a, b  in  [3:0]  slice operands
//     cin   in         carry into bit 0
//     s     out [3:0]  slice sum
//     cout  out        carry out of bit 3
// -----------------------------------------------------------------------------
module somador_4_bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] carry;

  // Bit-level ripple: carry[i] feeds bit i, carry[i+1] leaves it.
  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[4];

endmodule : somador_4_bits

// File: rtl/controle_somador_serial.sv
// -----------------------------------------------------------------------------
// controle_somador_serial
//   Computes a LARG_TOTAL-bit sum by time-multiplexing a single somador_4_bits
//   slice, one nibble per cycle, LSB first, with the carry registered between
//   passes. Latency from acceptance to out_valid is QTD_BLOCOS+1 cycles.
//
//   Optional feature: define CONTROLE_SOMADOR_OVERFLOW_EN to add the signed
//   overflow output; without it the port and its logic are absent.
//
//   Handshake (both sides): a transfer happens on a rising edge where valid and
//   ready are both 1. in_ready is 1 only in OCIOSO; out_valid is 1 only in
//   PRONTO, and vetr/cout (and overflow) stay stable while out_valid=1 and
//   out_ready=0. Both are pure functions of the state register.
//
//   Ports:
//     clk        in                 clock, rising edge
//     rst        in                 synchronous active-high reset
//     in_valid   in                 operands and cin presented
//     in_ready   out                controller can accept operands
//     vet1       in  [LARG_TOTAL]   operand A
//     vet2       in  [LARG_TOTAL]   operand B
//     cin        in                 carry into bit 0
//     out_valid  out                vetr/cout hold a completed result
//     out_ready  in                 consumer accepts the result
//     vetr       out [LARG_TOTAL]   sum
//     cout       out                carry out of the MSB
//     overflow   out                signed overflow (optional feature only)
//     estado_dbg out [2]            current FSM state, for debug/checkers
// -----------------------------------------------------------------------------
module controle_somador_serial
  import controle_somador_serial_pkg::*;
#(
  // Must be a positive multiple of LARG_BLOCO.
  parameter int LARG_TOTAL = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LARG_TOTAL-1:0] vet1,
  input  logic [LARG_TOTAL-1:0] vet2,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LARG_TOTAL-1:0] vetr,
  output logic                  cout,
`ifdef CONTROLE_SOMADOR_OVERFLOW_EN
  output logic                  overflow,
`endif
  output logic [1:0]            estado_dbg
);

  localparam int QTD_BLOCOS = LARG_TOTAL / LARG_BLOCO;
  // Keep the index at least one bit wide so QTD_BLOCOS=1 still elaborates.
  localparam int IDX_W      = (QTD_BLOCOS > 1) ? $clog2(QTD_BLOCOS) : 1;
  localparam logic [IDX_W-1:0] IDX_ULTIMO = IDX_W'(QTD_BLOCOS - 1);
  localparam int MSB        = LARG_TOTAL - 1;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  estado_t               estado_q, estado_d;
  logic [LARG_TOTAL-1:0] vet1_q,   vet1_d;
  logic [LARG_TOTAL-1:0] vet2_q,   vet2_d;
  logic [LARG_TOTAL-1:0] vetr_q,   vetr_d;
  logic                  carry_q,  carry_d;
  logic                  cout_q,   cout_d;
  logic [IDX_W-1:0]      idx_q,    idx_d;
`ifdef CONTROLE_SOMADOR_OVERFLOW_EN
  logic                  ovf_q,    ovf_d;
`endif

  // ---------------------------------------------------------------------------
  // Shared adder slice: always fed from the latched operands, never from the
  // live input ports, so operand changes after acceptance are harmless.
  // ---------------------------------------------------------------------------
  logic [LARG_BLOCO-1:0] fatia_a;
  logic [LARG_BLOCO-1:0] fatia_b;
  logic [LARG_BLOCO-1:0] fatia_soma;
  logic                  fatia_cout;

  assign fatia_a = vet1_q[idx_q*LARG_BLOCO +: LARG_BLOCO];
  assign fatia_b = vet2_q[idx_q*LARG_BLOCO +: LARG_BLOCO];

  somador_4_bits u_fatia (
    .a    (fatia_a),
    .b    (fatia_b),
    .cin  (carry_q),
    .s    (fatia_soma),
    .cout (fatia_cout)
  );

  // ---------------------------------------------------------------------------
  // Register process
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      vet1_q   <= '0;
      vet2_q   <= '0;
      vetr_q   <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      idx_q    <= '0;
`ifdef CONTROLE_SOMADOR_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      vet1_q   <= vet1_d;
      vet2_q   <= vet2_d;
      vetr_q   <= vetr_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      idx_q    <= idx_d;
`ifdef CONTROLE_SOMADOR_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath process
  // ---------------------------------------------------------------------------
  always_comb begin
    estado_d = estado_q;
    vet1_d   = vet1_q;
    vet2_d   = vet2_q;
    vetr_d   = vetr_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    idx_d    = idx_q;
`ifdef CONTROLE_SOMADOR_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif

    case (estado_q)
      OCIOSO: begin
        if (in_valid) begin
          vet1_d   = vet1;
          vet2_d   = vet2;
          // The external carry-in seeds the carry register for slice 0.
          carry_d  = cin;
          idx_d    = '0;
          estado_d = SOMANDO;
        end
      end

      SOMANDO: begin
        // Only the current slice of vetr changes; upper slices keep their old
        // contents until their own pass.
        vetr_d[idx_q*LARG_BLOCO +: LARG_BLOCO] = fatia_soma;
        carry_d = fatia_cout;
        if (idx_q == IDX_ULTIMO) begin
          cout_d   = fatia_cout;
`ifdef CONTROLE_SOMADOR_OVERFLOW_EN
          // Final slice holds the MSB: overflow when both operands share a
          // sign and the sum's sign differs from it.
          ovf_d    = (vet1_q[MSB] == vet2_q[MSB]) &&
                     (fatia_soma[LARG_BLOCO-1] != vet1_q[MSB]);
`endif
          // Wrap back to 0 so idx never leaves 0..QTD_BLOCOS-1.
          idx_d    = '0;
          estado_d = PRONTO;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      PRONTO: begin
        // Result registers are untouched here; in_valid is ignored.
        if (out_ready) begin
          estado_d = OCIOSO;
        end
      end

      default: begin
        // Unused encoding: fall back to idle.
        estado_d = OCIOSO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready   = (estado_q == OCIOSO);
  assign out_valid  = (estado_q == PRONTO);
  assign vetr       = vetr_q;
  assign cout       = cout_q;
  assign estado_dbg = estado_q;
`ifdef CONTROLE_SOMADOR_OVERFLOW_EN
  assign overflow   = ovf_q;
`endif

endmodule : controle_somador_serial

// File: doc/controle_somador_serial.md
Name: controle_somador_serial

Overview:
- Sequencing controller that computes a LARG_TOTAL-bit sum by time-multiplexing a single somador_4_bits slice, one nibble per cycle, LSB first.
- Carry is registered between cycles.
- Trades the area of the parallel 8-bit ripple adder for QTD_BLOCOS cycles of latency.
- Valid/ready handshake on both the operand side and the result side, so it drops into a pipelined datapath.

Parameters:
- LARG_TOTAL, 8: total operand/result width; must be a positive multiple of LARG_BLOCO.
- LARG_BLOCO, 4: slice width; fixed by somador_4_bits, not overridable in practice.
- QTD_BLOCOS, LARG_TOTAL/LARG_BLOCO: number of slice passes (derived localparam).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and cin presented.
- in_ready  out  1  controller can accept operands (state OCIOSO).
- vet1  in  LARG_TOTAL  operand A.
- vet2  in  LARG_TOTAL  operand B.
- cin  in  1  carry-in for bit 0.
- out_valid  out  1  vetr/cout hold a completed result.
- out_ready  in  1  consumer accepts the result.
- vetr  out  LARG_TOTAL  sum.
- cout  out  1  carry-out of the MSB.
- overflow  out  1  signed overflow (only with OVERFLOW_EN).

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - rst dominates every other input in the same cycle.
- Reset values:
  - State = OCIOSO, in_ready=1, out_valid=0.
  - vetr=0, cout=0, overflow=0.
  - Internal operand registers, carry register and index counter all cleared.
- State OCIOSO:
  - in_ready=1, out_valid=0.
  - On in_valid=1: latch vet1, vet2 and cin; clear the index (idx) to 0; go to SOMANDO.
- State SOMANDO:
  - in_ready=0.
  - Each cycle drives slice idx of the latched operands and the carry register into the one somador_4_bits instance.
  - Writes the slice sum into vetr[idx*4 +: 4] and the slice cout into the carry register.
  - Increments idx.
  - When idx==QTD_BLOCOS-1: cout <= slice cout and go to PRONTO.
- State PRONTO:
  - out_valid=1; vetr and cout are held stable.
  - in_ready=0; in_valid is ignored.
  - On out_ready=1: go to OCIOSO (out_valid falls the next cycle).
- Latency:
  - Operands accepted in cycle T give out_valid=1 in cycle T+QTD_BLOCOS+1 (cycle T+3 for defaults).
  - Minimum throughput is one result per QTD_BLOCOS+2 cycles.
- vetr during SOMANDO:
  - Holds a partially updated value; it is undefined to consumers while out_valid=0.
  - Upper slices keep their previous contents until they are overwritten.
- Operand capture:
  - Inputs changing after acceptance have no effect; only latched copies are used.
- Reset mid-operation:
  - Any state returns to OCIOSO on the next edge, with all outputs at their reset values.
  - The in-flight result is discarded and never signalled.
- Arithmetic:
  - Unsigned modulo 2^LARG_TOTAL.
  - {cout,vetr} == vet1+vet2+cin exactly.
- Wrap-around: idx counts 0..QTD_BLOCOS-1 only and never exceeds that range.
- Illegal state encoding: recovers to OCIOSO.

Optional Feature:
- Macro: CONTROLE_SOMADOR_OVERFLOW_EN.
- When defined:
  - Port overflow exists.
  - It is set in the final SOMANDO cycle as (vet1[MSB]==vet2[MSB]) && (sum[MSB]!=vet1[MSB]), using the latched operands and the final slice sum.
  - It is held with vetr through PRONTO and cleared on reset.
- When undefined:
  - Port and logic are absent.
  - Behaviour is otherwise identical.

Decomposition:
- Shared package/include holds:
  - State encodings OCIOSO=2'd0, SOMANDO=2'd1, PRONTO=2'd2.
  - Constant LARG_BLOCO=4.
- Sub-module: the existing somador_4_bits, instantiated exactly once as the shared slice; no new sub-module.
- The controller is the FSM, the idx counter, and the operand/carry/result registers.

Test Plan:
- Reset, then vet1=0x3C, vet2=0x5A, cin=0, out_ready=1: out_valid rises 3 cycles after acceptance with vetr=0x96, cout=0; in_ready=0 for cycles T+1..T+3.
- vet1=0xFF, vet2=0x01, cin=0 → vetr=0x00, cout=1. Then vet1=0xFF, vet2=0x00, cin=1 → vetr=0x00, cout=1 (carry crosses the nibble boundary through the register).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid; vetr/cout stay stable and in_valid pulses are ignored; release → return to OCIOSO, and the next operands 0x01+0x01 give 0x02.
- Change vet1/vet2 to 0xAA/0xAA during SOMANDO after accepting 0x10+0x20: result is still 0x30, cout=0.
- Assert rst in the first SOMANDO cycle: next cycle in_ready=1, out_valid=0, vetr=0, cout=0; no spurious out_valid follows.
- With CONTROLE_SOMADOR_OVERFLOW_EN: 0x7F+0x01 → vetr=0x80, overflow=1, cout=0; 0x80+0x80 → vetr=0x00, overflow=1, cout=1; 0x10+0x20 → overflow=0.
